// File: rtl/bg_pkg.sv
// Shared types and constants for the rotation/scaling background coordinate path.
// Reference points are signed 20.8 fixed point; affine parameters are signed 8.8.
package bg_pkg;
    localparam int REF_W    = 28;
    localparam int COORD_W  = 10;
    localparam int H_PIXELS = 240;
    localparam int INT_W    = REF_W - 8;
    localparam int CNT_W    = 8;

    typedef logic signed [REF_W-1:0] fixed_20_8_t;
    typedef logic signed [15:0]      fixed_8_8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } affine_state_t;

    function automatic fixed_20_8_t sext_param(input fixed_8_8_t p);
        return {{(REF_W-16){p[15]}}, p};
    endfunction
endpackage

// File: rtl/affine_coord_map.sv
// Maps the signed integer part of one affine axis onto a texel coordinate,
// either wrapped into the background size or flagged when it falls outside it.
module affine_coord_map
    import bg_pkg::*;
(
    input  logic signed [INT_W-1:0] ix_i,
    input  logic [COORD_W-1:0]      max_i,
    input  logic                    wrap_i,
    output logic [COORD_W-1:0]      coord_o,
    output logic                    oor_o
);
    logic signed [INT_W-1:0] max_ext_s;

    // Wrap masks with the power-of-two size; otherwise full-width signed range test.
    always_comb begin
        max_ext_s = {{(INT_W-COORD_W){1'b0}}, max_i};
        if (wrap_i) begin
            coord_o = ix_i[COORD_W-1:0] & max_i;
            oor_o   = 1'b0;
        end else begin
            coord_o = ix_i[COORD_W-1:0];
            oor_o   = ix_i[INT_W-1] | (ix_i > max_ext_s);
        end
    end
endmodule

// File: rtl/affine_coord_gen.sv
// Affine reference-point stepper streaming one texel coordinate per accepted pixel.
// Optional macro AFFINE_MOSAIC_EN adds horizontal mosaic via mosaic_h.
module affine_coord_gen
    import bg_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ref_x_wr,
    input  fixed_20_8_t         ref_x_in,
    input  logic                ref_y_wr,
    input  fixed_20_8_t         ref_y_in,
    input  fixed_8_8_t          pa,
    input  fixed_8_8_t          pb,
    input  fixed_8_8_t          pc,
    input  fixed_8_8_t          pd,
    input  logic [COORD_W-1:0]  hmax,
    input  logic [COORD_W-1:0]  vmax,
    input  logic                wrap,
`ifdef AFFINE_MOSAIC_EN
    input  logic [3:0]          mosaic_h,
`endif
    input  logic                vblank_start,
    input  logic                line_start,
    input  logic                pix_ready,
    output logic                valid,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic                out_of_range,
    output logic                line_done
);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(H_PIXELS - 1);

    affine_state_t     state_q;
    fixed_20_8_t       bg_x_q, bg_y_q, lx_q, ly_q, cur_x_q, cur_y_q;
    fixed_20_8_t       cur_x_d, cur_y_d;
    logic [CNT_W-1:0]  count_q;
    logic              valid_q, oor_q, line_done_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic              accept_s, last_s, update_s;
    logic [COORD_W-1:0] map_x_s, map_y_s;
    logic              oor_x_s, oor_y_s;
`ifdef AFFINE_MOSAIC_EN
    logic [3:0]        mos_cnt_q, mos_cnt_d;
`endif

    assign accept_s = (state_q == RUN) & valid_q & pix_ready;
    assign last_s   = accept_s & (count_q == LAST_PIX);

    // The mappers see the post-step position so an accepted pixel is replaced in the same edge.
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (accept_s) begin
            cur_x_d = cur_x_q + sext_param(pa);
            cur_y_d = cur_y_q + sext_param(pc);
        end else begin
            cur_x_d = cur_x_q;
            cur_y_d = cur_y_q;
        end
    end

    // Decides whether this accept refreshes the emitted coordinate.
    always_comb begin
`ifdef AFFINE_MOSAIC_EN
        mos_cnt_d = (mos_cnt_q == mosaic_h) ? 4'd0 : mos_cnt_q + 4'd1;
        update_s  = (mos_cnt_d == 4'd0);
`else
        update_s  = 1'b1;
`endif
    end

    affine_coord_map u_map_x (
        .ix_i    (cur_x_d[REF_W-1:8]),
        .max_i   (hmax),
        .wrap_i  (wrap),
        .coord_o (map_x_s),
        .oor_o   (oor_x_s)
    );

    affine_coord_map u_map_y (
        .ix_i    (cur_y_d[REF_W-1:8]),
        .max_i   (vmax),
        .wrap_i  (wrap),
        .coord_o (map_y_s),
        .oor_o   (oor_y_s)
    );

    // Reference registers, line FSM and registered pixel outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bg_x_q      <= '0;
            bg_y_q      <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            oor_q       <= 1'b0;
            line_done_q <= 1'b0;
`ifdef AFFINE_MOSAIC_EN
            mos_cnt_q   <= 4'd0;
`endif
        end else begin
            line_done_q <= 1'b0;

            // CPU write beats the vblank reload, which beats the per-line advance.
            if (ref_x_wr) begin
                bg_x_q <= ref_x_in;
                lx_q   <= ref_x_in;
            end else if (vblank_start) begin
                lx_q <= bg_x_q;
            end else if (last_s) begin
                lx_q <= lx_q + sext_param(pb);
            end else begin
                lx_q <= lx_q;
            end

            if (ref_y_wr) begin
                bg_y_q <= ref_y_in;
                ly_q   <= ref_y_in;
            end else if (vblank_start) begin
                ly_q <= bg_y_q;
            end else if (last_s) begin
                ly_q <= ly_q + sext_param(pd);
            end else begin
                ly_q <= ly_q;
            end

            if (line_start) begin
                state_q <= LOAD;
                cur_x_q <= ref_x_wr ? ref_x_in : lx_q;
                cur_y_q <= ref_y_wr ? ref_y_in : ly_q;
                count_q <= '0;
                valid_q <= 1'b0;
`ifdef AFFINE_MOSAIC_EN
                mos_cnt_q <= 4'd0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    LOAD: begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        x_q     <= map_x_s;
                        y_q     <= map_y_s;
                        oor_q   <= oor_x_s | oor_y_s;
`ifdef AFFINE_MOSAIC_EN
                        mos_cnt_q <= 4'd0;
`endif
                    end
                    RUN: begin
                        if (accept_s) begin
                            cur_x_q <= cur_x_d;
                            cur_y_q <= cur_y_d;
                            if (last_s) begin
                                valid_q     <= 1'b0;
                                line_done_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                count_q <= count_q + 8'd1;
                                if (update_s) begin
                                    x_q   <= map_x_s;
                                    y_q   <= map_y_s;
                                    oor_q <= oor_x_s | oor_y_s;
                                end else begin
                                    x_q   <= x_q;
                                end
                            end
`ifdef AFFINE_MOSAIC_EN
                            mos_cnt_q <= mos_cnt_d;
`endif
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign valid        = valid_q;
    assign x            = x_q;
    assign y            = y_q;
    assign out_of_range = oor_q;
    assign line_done    = line_done_q;
endmodule

// File: tb/tb_affine_coord_gen.sv
// Directed bench for affine_coord_gen: identity, scaling, wrap, backpressure,
// reference writes, line abort and asynchronous reset.
module tb_affine_coord_gen;
    import bg_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               ref_x_wr, ref_y_wr;
    logic [REF_W-1:0]   ref_x_in, ref_y_in;
    logic [15:0]        pa, pb, pc, pd;
    logic [COORD_W-1:0] hmax, vmax;
    logic               wrap, vblank_start, line_start, pix_ready;
    logic               valid, out_of_range, line_done;
    logic [COORD_W-1:0] x, y;

    int checks = 0;
    int passed = 0;

    logic [COORD_W-1:0] obs_x [H_PIXELS];
    logic [COORD_W-1:0] obs_y [H_PIXELS];
    logic               obs_o [H_PIXELS];
    int                 obs_n;

    affine_coord_gen dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ref_x_wr     (ref_x_wr),
        .ref_x_in     (ref_x_in),
        .ref_y_wr     (ref_y_wr),
        .ref_y_in     (ref_y_in),
        .pa           (pa),
        .pb           (pb),
        .pc           (pc),
        .pd           (pd),
        .hmax         (hmax),
        .vmax         (vmax),
        .wrap         (wrap),
        .vblank_start (vblank_start),
        .line_start   (line_start),
        .pix_ready    (pix_ready),
        .valid        (valid),
        .x            (x),
        .y            (y),
        .out_of_range (out_of_range),
        .line_done    (line_done)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic write_ref(input logic [REF_W-1:0] xv, input logic [REF_W-1:0] yv);
        ref_x_wr = 1'b1; ref_x_in = xv;
        ref_y_wr = 1'b1; ref_y_in = yv;
        step();
        ref_x_wr = 1'b0; ref_y_wr = 1'b0;
    endtask

    // Runs one whole line, recording every accepted pixel into obs_*.
    task automatic capture(input int stall_at, input int stall_len, input int wr_at,
                           input logic [REF_W-1:0] wr_val, input logic ls_wr);
        int stalls;
        logic wr_done, early_done;
        logic [COORD_W-1:0] held_x;
        stalls = 0; wr_done = 1'b0; early_done = 1'b0; held_x = '0;
        obs_n = 0;
        pix_ready = 1'b1;
        line_start = 1'b1;
        ref_y_wr = ls_wr; ref_y_in = wr_val;
        step();
        line_start = 1'b0; ref_y_wr = 1'b0;
        checks++;
        if (valid !== 1'b0) $display("FAIL load_valid: got %b expected 0", valid);
        else passed++;
        step();
        checks++;
        if (valid !== 1'b1) $display("FAIL first_valid_latency: got %b expected 1", valid);
        else passed++;
        for (int cyc = 0; cyc < 600 && obs_n < H_PIXELS; cyc++) begin
            if (line_done) early_done = 1'b1;
            if (valid && obs_n == stall_at && stalls < stall_len) begin
                if (stalls == 0) held_x = x;
                checks++;
                if (x !== held_x || valid !== 1'b1)
                    $display("FAIL stall_hold: got x=%0d valid=%b expected x=%0d valid=1", x, valid, held_x);
                else passed++;
                pix_ready = 1'b0;
                stalls++;
            end else if (valid) begin
                pix_ready = 1'b1;
                obs_x[obs_n] = x; obs_y[obs_n] = y; obs_o[obs_n] = out_of_range;
                obs_n++;
            end else begin
                pix_ready = 1'b1;
            end
            if (obs_n == wr_at && !wr_done) begin
                ref_y_wr = 1'b1; ref_y_in = wr_val; wr_done = 1'b1;
            end else begin
                ref_y_wr = 1'b0;
            end
            step();
        end
        ref_y_wr = 1'b0;
        checks++;
        if (obs_n != H_PIXELS || early_done)
            $display("FAIL accept_count: got %0d accepts early_done=%b expected %0d", obs_n, early_done, H_PIXELS);
        else passed++;
        checks++;
        if (line_done !== 1'b1 || valid !== 1'b0)
            $display("FAIL line_done_pulse: got done=%b valid=%b expected 1/0", line_done, valid);
        else passed++;
        step();
        checks++;
        if (line_done !== 1'b0) $display("FAIL line_done_width: got %b expected 0", line_done);
        else passed++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        ref_x_wr = 1'b0; ref_y_wr = 1'b0; ref_x_in = '0; ref_y_in = '0;
        pa = 16'h0100; pb = 16'h0000; pc = 16'h0000; pd = 16'h0100;
        hmax = 10'd255; vmax = 10'd255; wrap = 1'b0;
        vblank_start = 1'b0; line_start = 1'b0; pix_ready = 1'b1;
        step(); step();
        checks++;
        if ({valid, x, y, out_of_range, line_done} !== 23'd0)
            $display("FAIL reset_outputs: got v=%b x=%0d y=%0d o=%b d=%b expected all 0", valid, x, y, out_of_range, line_done);
        else passed++;
        reset_n = 1'b1;
        step();
        vblank_start = 1'b1; step(); vblank_start = 1'b0;
    endtask

    task automatic test_identity;
        int bad;
        for (int ln = 0; ln < 2; ln++) begin
            capture(-1, 0, -1, '0, 1'b0);
            bad = 0;
            for (int i = 0; i < H_PIXELS; i++)
                if (obs_x[i] !== COORD_W'(i) || obs_y[i] !== COORD_W'(ln) || obs_o[i] !== 1'b0) bad++;
            checks++;
            if (bad != 0) $display("FAIL identity_line%0d: got %0d bad pixels, x[5]=%0d y[0]=%0d expected 0 bad", ln, bad, obs_x[5], obs_y[0]);
            else passed++;
        end
    endtask

    task automatic test_scale;
        int bad;
        pa = 16'h0200;
        write_ref(28'h0000180, 28'h0000000);
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_x[0] !== 10'd1 || obs_x[1] !== 10'd3 || obs_x[127] !== 10'd255 || obs_o[127] !== 1'b0)
            $display("FAIL scale_low: got x0=%0d x1=%0d x127=%0d o127=%b expected 1 3 255 0", obs_x[0], obs_x[1], obs_x[127], obs_o[127]);
        else passed++;
        checks++;
        if (obs_x[128] !== 10'd257 || obs_o[128] !== 1'b1)
            $display("FAIL scale_edge: got x128=%0d o=%b expected 257 1", obs_x[128], obs_o[128]);
        else passed++;
        bad = 0;
        for (int i = 0; i < H_PIXELS; i++)
            if (obs_x[i] !== COORD_W'(2*i+1) || obs_o[i] !== (2*i+1 > 255)) bad++;
        checks++;
        if (bad != 0) $display("FAIL scale_all: got %0d bad pixels expected 0", bad);
        else passed++;
    endtask

    task automatic test_wrap;
        int bad;
        wrap = 1'b1;
        write_ref(28'h0000180, 28'h0000000);
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_x[128] !== 10'd1 || obs_o[128] !== 1'b0)
            $display("FAIL wrap_edge: got x128=%0d o=%b expected 1 0", obs_x[128], obs_o[128]);
        else passed++;
        bad = 0;
        for (int i = 0; i < H_PIXELS; i++)
            if (obs_x[i] !== COORD_W'((2*i+1) & 255) || obs_o[i] !== 1'b0) bad++;
        checks++;
        if (bad != 0) $display("FAIL wrap_all: got %0d bad pixels expected 0", bad);
        else passed++;
        pa = 16'h0100;
        write_ref(28'hFFFFF00, 28'h0000000);
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_x[0] !== 10'd255 || obs_x[1] !== 10'd0 || obs_o[0] !== 1'b0)
            $display("FAIL wrap_negative: got x0=%0d x1=%0d o=%b expected 255 0 0", obs_x[0], obs_x[1], obs_o[0]);
        else passed++;
        wrap = 1'b0;
        write_ref(28'hFFFFF00, 28'h0000000);
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_x[0] !== 10'd1023 || obs_o[0] !== 1'b1 || obs_x[1] !== 10'd0 || obs_o[1] !== 1'b0)
            $display("FAIL nowrap_negative: got x0=%0d o0=%b x1=%0d o1=%b expected 1023 1 0 0", obs_x[0], obs_o[0], obs_x[1], obs_o[1]);
        else passed++;
    endtask

    task automatic test_backpressure;
        int bad;
        write_ref(28'h0000000, 28'h0000000);
        capture(10, 3, -1, '0, 1'b0);
        checks++;
        if (obs_x[10] !== 10'd10 || obs_x[11] !== 10'd11)
            $display("FAIL bp_resume: got x10=%0d x11=%0d expected 10 11", obs_x[10], obs_x[11]);
        else passed++;
        bad = 0;
        for (int i = 0; i < H_PIXELS; i++)
            if (obs_x[i] !== COORD_W'(i)) bad++;
        checks++;
        if (bad != 0) $display("FAIL bp_all: got %0d bad pixels expected 0", bad);
        else passed++;
    endtask

    task automatic test_midframe_write;
        int bad;
        pd = 16'h0000;
        write_ref(28'h0000000, 28'h0000000);
        capture(-1, 0, 100, 28'h0000A00, 1'b0);
        bad = 0;
        for (int i = 0; i < H_PIXELS; i++) if (obs_y[i] !== 10'd0) bad++;
        checks++;
        if (bad != 0) $display("FAIL midwrite_current: got %0d bad y expected 0", bad);
        else passed++;
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_y[0] !== 10'd10 || obs_y[239] !== 10'd10)
            $display("FAIL midwrite_next: got y0=%0d y239=%0d expected 10", obs_y[0], obs_y[239]);
        else passed++;
        capture(-1, 0, -1, 28'h0001400, 1'b1);
        checks++;
        if (obs_y[0] !== 10'd20 || obs_y[239] !== 10'd20)
            $display("FAIL linestart_bypass: got y0=%0d y239=%0d expected 20", obs_y[0], obs_y[239]);
        else passed++;
    endtask

    task automatic test_abort;
        logic saw_done;
        pd = 16'h0100;
        write_ref(28'h0000000, 28'h0000300);
        pix_ready = 1'b1;
        line_start = 1'b1; step(); line_start = 1'b0;
        step();
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (line_done) saw_done = 1'b1;
            step();
        end
        checks++;
        if (x !== 10'd50 || y !== 10'd3) $display("FAIL abort_pre: got x=%0d y=%0d expected 50 3", x, y);
        else passed++;
        line_start = 1'b1; step(); line_start = 1'b0;
        if (line_done) saw_done = 1'b1;
        step();
        if (line_done) saw_done = 1'b1;
        checks++;
        if (valid !== 1'b1 || x !== 10'd0 || y !== 10'd3 || saw_done)
            $display("FAIL abort_restart: got v=%b x=%0d y=%0d done=%b expected 1 0 3 0", valid, x, y, saw_done);
        else passed++;
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_y[0] !== 10'd3) $display("FAIL abort_no_advance: got y=%0d expected 3", obs_y[0]);
        else passed++;
        capture(-1, 0, -1, '0, 1'b0);
        checks++;
        if (obs_y[0] !== 10'd4) $display("FAIL abort_then_advance: got y=%0d expected 4", obs_y[0]);
        else passed++;
    endtask

    task automatic test_reset_midline;
        pix_ready = 1'b1;
        line_start = 1'b1; step(); line_start = 1'b0;
        for (int i = 0; i < 21; i++) step();
        checks++;
        if (valid !== 1'b1 || y !== 10'd5 || x !== 10'd20)
            $display("FAIL prereset_state: got v=%b x=%0d y=%0d expected 1 20 5", valid, x, y);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || x !== 10'd0 || y !== 10'd0)
            $display("FAIL async_reset: got v=%b x=%0d y=%0d expected 0 0 0", valid, x, y);
        else passed++;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_scale();
        test_wrap();
        test_backpressure();
        test_midframe_write();
        test_abort();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/affine_coord_gen.md
Name: affine_coord_gen

Overview:
- Producer side of the background texture-coordinate interface for rotation/scaling backgrounds.
- Keeps the per-frame and per-line affine reference point (BGxX/BGxY) and steps it by the PA/PB/PC/PD parameters.
- Streams one integer (x, y) texel coordinate per pixel, plus a range flag, to the overflow handler and tile fetch path.
- Applies wrap-around itself when the background's overflow/wrap bit is set.

Parameters:
- REF_W, 28, width of reference point; signed 20.8 fixed point.
- COORD_W, 10, width of emitted integer coordinate.
- H_PIXELS, 240, pixels emitted per scanline.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ref_x_wr  in  1  CPU write strobe for BGxX
- ref_x_in  in  REF_W  BGxX write data, signed 20.8
- ref_y_wr  in  1  CPU write strobe for BGxY
- ref_y_in  in  REF_W  BGxY write data, signed 20.8
- pa, pb, pc, pd  in  16 each  signed 8.8 affine parameters
- hmax, vmax  in  COORD_W  background size minus 1; always 2^n-1
- wrap  in  1  overflow/wrap control bit of the background
- vblank_start  in  1  one-cycle pulse at start of vblank
- line_start  in  1  one-cycle pulse at start of visible scanline
- pix_ready  in  1  downstream accepts coordinate
- valid  out  1  x/y/out_of_range hold a pixel
- x, y  out  COORD_W  texel coordinate
- out_of_range  out  1  coordinate outside 0..hmax / 0..vmax and wrap=0
- line_done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset values:
  - All registers 0: bg_x, bg_y, lx, ly, cur_x, cur_y, count.
  - State IDLE.
  - valid=0, x=0, y=0, out_of_range=0, line_done=0.
- Register roles:
  - bg_x/bg_y are the programmed registers.
  - lx/ly are the internal line references.
- ref_x_wr loads bg_x and lx with ref_x_in in the same cycle. ref_y_wr does the same for bg_y/ly.
- vblank_start: lx<=bg_x, ly<=bg_y. A CPU write in the same cycle wins; both registers take the write data.
- FSM states: IDLE, LOAD, RUN.
- IDLE→LOAD on line_start:
  - cur_x<=lx, cur_y<=ly, count<=0.
  - If ref_*_wr is in the same cycle, the write data is bypassed into cur_*.
- LOAD→RUN next cycle; output regs are computed from cur_*. valid=1 from the cycle after LOAD, so latency from line_start to first valid is 2 cycles.
- RUN, valid & pix_ready:
  - cur_x += sext(pa); cur_y += sext(pc); count++.
  - Next outputs register from the new cur_* on the following edge, giving one coordinate per cycle under continuous ready.
- RUN, valid & !pix_ready: x, y, out_of_range, valid hold stable.
- Last pixel accepted (count==H_PIXELS-1):
  - lx += sext(pb); ly += sext(pd).
  - line_done=1 for one cycle; valid=0; state→IDLE.
- line_start while in RUN or LOAD aborts the current line and restarts at LOAD. lx/ly are not advanced for the aborted line; line_done is not pulsed.
- vblank_start during RUN updates lx/ly only; the current line continues from cur_*.
- Arithmetic:
  - All accumulation is modulo 2^REF_W; overflow wraps silently.
  - Integer part ix = cur[REF_W-1:8], signed.
- Coordinate mapping:
  - wrap=1: x = ix[COORD_W-1:0] & hmax; y likewise with vmax; out_of_range=0.
  - wrap=0: x = ix[COORD_W-1:0]; out_of_range=1 if ix<0 or ix>hmax, or iy<0 or iy>vmax (full-width signed compare).
- wrap, hmax and vmax are sampled combinationally at the output register load.

Optional Feature:
- Macro: AFFINE_MOSAIC_EN.
- When defined:
  - Adds input mosaic_h[3:0].
  - The emitted x/y/out_of_range are updated only on every (mosaic_h+1)-th accepted pixel within the line, counted from pixel 0; otherwise they repeat the held value.
  - cur_x/cur_y still step every accepted pixel.
  - The mosaic counter resets at LOAD.
- When undefined: no port, and every accepted pixel updates the outputs.

Decomposition:
- Shared package bg_pkg holds:
  - REF_W, COORD_W, H_PIXELS
  - typedef fixed_20_8_t (signed [27:0])
  - typedef fixed_8_8_t (signed [15:0])
  - enum affine_state_t {IDLE, LOAD, RUN}
- One sub-module, affine_coord_map: combinational mapping of cur_x/cur_y plus hmax/vmax/wrap to x/y/out_of_range. The top instantiates two, one per axis, and ORs the range flags.

Test Plan:
- Identity step: ref=0, pa=0x0100, pc=0, pd=0x0100, hmax=vmax=255, wrap=0, pix_ready=1 → x=0..239 over 240 cycles, y=0; line_done after x=239; next line y=1.
- Scale 2×: pa=0x0200, ref_x=0x000180 (1.5) → x=1,3,5,…; pixel 127 gives ix=255; pixel 128 gives ix=257>255 → out_of_range=1.
- Wrap: same as the scale case with wrap=1 → pixel 128 gives x=257&255=1, out_of_range=0. Negative ref_x=-0x100 → x=255.
- Backpressure: drop pix_ready for 3 cycles at pixel 10 → x stays 10 with valid=1; resumes at 11; still exactly 240 accepts.
- Register write mid-frame: write ref_y=0x0A00 during RUN → current line unaffected; next line y=10. The same write in the cycle of line_start → that line already uses y=10.
- Reset/abort: reset_n low mid-line → valid=0, x=y=0 immediately. line_start during RUN → restart from lx with line_done not pulsed and ly not advanced.
